dmem_arbiter: RTL and testbench

- Shares the single-ported data memory between the core's MEM stage and an external debug/loader port. The loader is used by the testbench or a debug host to preload arrays and read results back.
- Sits between the EX/MEM pipeline register and data_mem.
- The core has priority. A bounded-starvation counter forces one external access after MAX_WAIT cycles of blocking; when that happens the core's MEM stage is stalled for one cycle.
- The external side uses a valid/ready request channel and a one-cycle ack response.

---
 rtl/dmem_arbiter.sv | 131 +++++++++++++
 tb/tb_dmem_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Shares the single-ported data memory between the core MEM stage (priority) and an
// external valid/ready loader port with bounded starvation. Optional DMEM_ARB_STATS_EN adds counters.
module dmem_arbiter #(
  parameter int unsigned AW       = 64,
  parameter int unsigned DW       = 64,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  input  logic          core_rd,
  input  logic          core_wr,
  output logic [DW-1:0] core_rdata,
  output logic          core_stall,
  input  logic          ext_valid,
  output logic          ext_ready,
  input  logic          ext_we,
  input  logic [AW-1:0] ext_addr,
  input  logic [DW-1:0] ext_wdata,
  output logic          ext_ack,
  output logic [DW-1:0] ext_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_rd,
  output logic          mem_wr,
  input  logic [DW-1:0] mem_rdata,
  output logic [31:0]   stat_stall_cycles,
  output logic [31:0]   stat_ext_xfers
);

  localparam int unsigned CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_LIMIT = CW'(MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    ACK
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] wait_cnt, wait_nxt;
  logic          held_we;
  logic [AW-1:0] held_addr;
  logic [DW-1:0] held_wdata;
  logic          core_req;
  logic          ext_go;
  logic          capture;

  // Handshake outputs are masked during reset so a request dropped by reset never acks.
  always_comb begin
    core_req   = core_rd | core_wr;
    ext_ready  = (state == IDLE) && !reset;
    ext_ack    = (state == ACK) && !reset;
    capture    = ext_ready && ext_valid;
    ext_go     = (state == PEND) && !reset && (!core_req || (wait_cnt == WAIT_LIMIT));
    core_stall = ext_go && core_req;
    core_rdata = mem_rdata;

    mem_addr  = core_addr;
    mem_wdata = core_wdata;
    mem_rd    = core_rd;
    mem_wr    = core_wr;
    if (ext_go) begin
      mem_addr  = held_addr;
      mem_wdata = held_wdata;
      mem_rd    = !held_we;
      mem_wr    = held_we;
    end
  end

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    case (state)
      IDLE: begin
        if (capture) begin
          state_nxt = PEND;
          wait_nxt  = '0;
        end
      end
      PEND: begin
        if (ext_go) begin
          state_nxt = ACK;
        end else if (wait_cnt != WAIT_LIMIT) begin
          wait_nxt = wait_cnt + 1'b1;
        end
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      held_we    <= 1'b0;
      held_addr  <= '0;
      held_wdata <= '0;
      ext_rdata  <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (capture) begin
        held_we    <= ext_we;
        held_addr  <= ext_addr;
        held_wdata <= ext_wdata;
      end
      if (ext_go && !held_we) begin
        ext_rdata <= mem_rdata;
      end
    end
  end

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_stall_cycles <= '0;
      stat_ext_xfers    <= '0;
    end else begin
      if (core_stall) stat_stall_cycles <= stat_stall_cycles + 32'd1;
      if (ext_ack)    stat_ext_xfers    <= stat_ext_xfers + 32'd1;
    end
  end
`else
  assign stat_stall_cycles = '0;
  assign stat_ext_xfers    = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed plus randomized bench for dmem_arbiter against a request-level model with a
// behavioural data memory attached to the mem_* port.
module tb_dmem_arbiter;
  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] core_addr, core_wdata, core_rdata;
  logic        core_rd, core_wr, core_stall;
  logic        ext_valid, ext_ready, ext_we, ext_ack;
  logic [63:0] ext_addr, ext_wdata, ext_rdata;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rd, mem_wr;
  logic [31:0] stat_stall_cycles, stat_ext_xfers;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(64), .DW(64), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_rd(core_rd), .core_wr(core_wr),
    .core_rdata(core_rdata), .core_stall(core_stall),
    .ext_valid(ext_valid), .ext_ready(ext_ready), .ext_we(ext_we), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_ack(ext_ack), .ext_rdata(ext_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata),
    .stat_stall_cycles(stat_stall_cycles), .stat_ext_xfers(stat_ext_xfers)
  );

  // Data memory: combinational read, write on clock edge, cleared by reset.
  logic [63:0] mem [256];
  assign mem_rdata = mem[mem_addr[7:0]];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (mem_wr) begin
      mem[mem_addr[7:0]] <= mem_wdata;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Request-level model: one outstanding external request, issued at the first
  // cycle after capture with no core traffic, or at the MAX_WAIT+1 deadline.
  logic [63:0] ref_mem [256];
  bit          m_busy, m_issued, m_we;
  int          m_cap, m_issue;
  logic [63:0] m_addr, m_wdata, m_rdata;
  int          exp_stalls, exp_xfers;
  bit          model_stall, model_ready;
  int          cyc = 0;
  int          obs_acks = 0, obs_stalls = 0, last_ack_cyc = -1, last_stall_cyc = -1;

  task automatic step();
    logic        creq, e_ready, e_ack, issuing, e_stall, e_rd, e_wr;
    logic [63:0] e_addr, e_wdata;
    @(negedge clk);
    creq = core_rd | core_wr;
    if (ext_ack)    begin obs_acks++;   last_ack_cyc   = cyc; end
    if (core_stall) begin obs_stalls++; last_stall_cyc = cyc; end
    if (reset) begin
      e_ready = 1'b0; e_ack = 1'b0; issuing = 1'b0;
    end else begin
      e_ready = !m_busy;
      e_ack   = m_busy && m_issued && (cyc == m_issue + 1);
      issuing = m_busy && !m_issued && (cyc > m_cap) && (!creq || (cyc == m_cap + 1 + MW));
    end
    e_stall = issuing && creq;
    if (issuing) begin
      e_addr = m_addr; e_wdata = m_wdata; e_wr = m_we; e_rd = !m_we;
    end else begin
      e_addr = core_addr; e_wdata = core_wdata; e_wr = core_wr; e_rd = core_rd;
    end
    chk("ext_ready", 64'(ext_ready), 64'(e_ready));
    chk("ext_ack", 64'(ext_ack), 64'(e_ack));
    chk("core_stall", 64'(core_stall), 64'(e_stall));
    chk("mem_rd", 64'(mem_rd), 64'(e_rd));
    chk("mem_wr", 64'(mem_wr), 64'(e_wr));
    if (e_rd || e_wr) chk("mem_addr", mem_addr, e_addr);
    if (e_wr)         chk("mem_wdata", mem_wdata, e_wdata);
    chk("core_rdata", core_rdata, mem_rdata);
    chk("ext_rdata", ext_rdata, m_rdata);
`ifdef DMEM_ARB_STATS_EN
    chk("stat_stall", 64'(stat_stall_cycles), 64'(32'(exp_stalls)));
    chk("stat_xfers", 64'(stat_ext_xfers), 64'(32'(exp_xfers)));
`else
    chk("stat_stall", 64'(stat_stall_cycles), 64'd0);
    chk("stat_xfers", 64'(stat_ext_xfers), 64'd0);
`endif
    if (reset) begin
      m_busy = 1'b0; m_rdata = '0; exp_stalls = 0; exp_xfers = 0;
      for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    end else begin
      if (issuing) begin
        m_issued = 1'b1; m_issue = cyc;
        if (m_we) ref_mem[m_addr[7:0]] = m_wdata;
        else      m_rdata = ref_mem[m_addr[7:0]];
      end else if (core_wr) begin
        ref_mem[core_addr[7:0]] = core_wdata;
      end
      if (e_stall) exp_stalls++;
      if (e_ack) begin m_busy = 1'b0; exp_xfers++; end
      if (ext_valid && e_ready) begin
        m_busy = 1'b1; m_issued = 1'b0; m_cap = cyc;
        m_we = ext_we; m_addr = ext_addr; m_wdata = ext_wdata;
      end
    end
    model_stall = e_stall;
    model_ready = e_ready;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic ext_req(input logic we, input logic [63:0] a, input logic [63:0] d);
    ext_valid = 1'b1; ext_we = we; ext_addr = a; ext_wdata = d;
    step();
    ext_valid = 1'b0;
  endtask

  int cap0, s0, a0;

  initial begin
    reset = 1'b1; core_rd = 1'b0; core_wr = 1'b0; core_addr = '0; core_wdata = '0;
    ext_valid = 1'b1; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;
    m_busy = 1'b0; m_issued = 1'b0; m_we = 1'b0; m_cap = 0; m_issue = 0;
    m_addr = '0; m_wdata = '0; m_rdata = '0; exp_stalls = 0; exp_xfers = 0;
    model_stall = 1'b0; model_ready = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;

    // Reset held two cycles with a request offered
    run(2);
    reset = 1'b0; ext_valid = 1'b0;
    step();
    chk("ready_after_rst", 64'(model_ready), 64'd1);

    // Core idle: write then read back, 2-cycle latency each, no stall
    s0 = obs_stalls;
    ext_req(1'b1, 64'h10, 64'hDEADBEEF); cap0 = m_cap;
    run(4);
    chk("wr_latency", 64'(last_ack_cyc - cap0), 64'd2);
    ext_req(1'b0, 64'h10, '0); cap0 = m_cap;
    run(4);
    chk("rd_latency", 64'(last_ack_cyc - cap0), 64'd2);
    chk("rd_data", ext_rdata, 64'hDEADBEEF);
    chk("idle_no_stall", 64'(obs_stalls - s0), 64'd0);

    // Continuous core loads: forced access at capture+5, ack at capture+6
    ext_req(1'b1, 64'h8, 64'h55);
    run(4);
    core_rd = 1'b1; core_addr = 64'h20;
    s0 = obs_stalls;
    ext_req(1'b0, 64'h8, '0); cap0 = m_cap;
    run(8);
    chk("forced_stall_cnt", 64'(obs_stalls - s0), 64'd1);
    chk("forced_stall_cyc", 64'(last_stall_cyc - cap0), 64'd5);
    chk("forced_ack_lat", 64'(last_ack_cyc - cap0), 64'(MW + 2));
    chk("forced_rd_data", ext_rdata, 64'h55);

    // Core load stream with a gap two cycles after capture
    s0 = obs_stalls;
    ext_req(1'b0, 64'h10, '0); cap0 = m_cap;
    step();
    core_rd = 1'b0;
    step();
    core_rd = 1'b1;
    run(3);
    core_rd = 1'b0;
    chk("gap_ack_lat", 64'(last_ack_cyc - cap0), 64'd3);
    chk("gap_no_stall", 64'(obs_stalls - s0), 64'd0);
    chk("gap_rd_data", ext_rdata, 64'hDEADBEEF);

    // Reset while a request is pending drops it
    core_rd = 1'b1;
    ext_req(1'b1, 64'h18, 64'h77);
    step();
    a0 = obs_acks;
    reset = 1'b1;
    step();
    reset = 1'b0;
    run(8);
    chk("rst_pend_no_ack", 64'(obs_acks - a0), 64'd0);
    core_rd = 1'b0;
    ext_req(1'b1, 64'h18, 64'h99); cap0 = m_cap;
    run(4);
    chk("post_rst_lat", 64'(last_ack_cyc - cap0), 64'd2);
    ext_req(1'b0, 64'h18, '0);
    run(4);
    chk("post_rst_data", ext_rdata, 64'h99);

    // Three forced accesses under continuous traffic from a clean reset
    reset = 1'b1;
    step();
    reset = 1'b0;
    core_rd = 1'b1; core_addr = 64'h30;
    for (int k = 0; k < 3; k++) begin
      ext_req(1'b0, 64'(k * 8), '0);
      run(7);
    end
    core_rd = 1'b0;
    step();
`ifdef DMEM_ARB_STATS_EN
    chk("stats_stall3", 64'(stat_stall_cycles), 64'd3);
    chk("stats_xfer3", 64'(stat_ext_xfers), 64'd3);
`else
    chk("stats_stall_tied", 64'(stat_stall_cycles), 64'd0);
    chk("stats_xfer_tied", 64'(stat_ext_xfers), 64'd0);
`endif

    // Randomized traffic; a stalled core op is held, an unaccepted request is held
    for (int n = 0; n < 1500; n++) begin
      int r;
      reset = ($urandom_range(0, 299) == 0);
      if (!model_stall) begin
        r = $urandom_range(0, 9);
        core_rd = (r < 4);
        core_wr = (r >= 4) && (r < 7);
        core_addr = 64'($urandom_range(0, 31));
        core_wdata = {$urandom, $urandom};
      end
      if (!(ext_valid && !model_ready)) begin
        ext_valid = ($urandom_range(0, 2) == 0);
        ext_we = $urandom_range(0, 1) == 1;
        ext_addr = 64'($urandom_range(0, 31));
        ext_wdata = {$urandom, $urandom};
      end
      step();
    end
    reset = 1'b0; core_rd = 1'b0; core_wr = 1'b0; ext_valid = 1'b0;
    run(MW + 4);
    for (int i = 0; i < 32; i++) chk("mem_contents", mem[i], ref_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
